// File: rtl/ravenna_hkspi.sv
// ravenna_hkspi: housekeeping SPI slave (mode 0) for the Ravenna SoC.
// The SPI pins are oversampled on clk. A command byte, an address byte and a
// stream of data bytes drive single-cycle read/write strobes into an 8-bit
// register file. The address auto-increments per data byte and wraps at 0xFF.
module ravenna_hkspi #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       SCK,
  input  logic       CSB,
  input  logic       SDI,
  output logic       SDO,
  output logic       sdo_enb,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_ADDR = 2'd2,
    S_DATA = 2'd3
  } state_t;

  state_t r_state, w_nstate;

  // synchronizers and edge detection
  logic [SYNC_STAGES-1:0] r_sck_sync, r_csb_sync, r_sdi_sync;
  logic w_sck, w_csb, w_sdi;
  logic r_sck_d, r_sdi_d, r_rise, r_fall;
  // armed once CSB has been seen high, so a frame cut by reset is never resumed
  logic r_armed;

  // byte assembly
  logic [2:0] r_bitcnt;
  logic [7:0] r_rx;
  logic       r_cmd_wr, r_cmd_rd;

  // register-file side and SDO side
  logic [7:0] r_addr, r_wdata, r_tx;
  logic       r_we, r_re, r_re_d;
  logic       r_sdo, r_sdo_enb;

  // decoded per-cycle events
  logic       w_active, w_rise_act, w_fall_act;
  logic       w_byte_done, w_cmd_done, w_addr_done, w_data_done;
  logic [7:0] w_byte;

  assign w_sck = r_sck_sync[SYNC_STAGES-1];
  assign w_csb = r_csb_sync[SYNC_STAGES-1];
  assign w_sdi = r_sdi_sync[SYNC_STAGES-1];

  // Pin synchronizers; CSB resets low so a fresh high level is needed to arm.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sck_sync <= '0;
      r_csb_sync <= '0;
      r_sdi_sync <= '0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
      r_csb_sync <= {r_csb_sync[SYNC_STAGES-2:0], CSB};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], SDI};
    end
  end

  // Registered SCK edge pulses, with SDI delayed to stay aligned to the rise pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sck_d <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_sdi_d <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sck_d <= w_sck;
      r_rise  <= w_sck & ~r_sck_d;
      r_fall  <= ~w_sck & r_sck_d;
      r_sdi_d <= w_sdi;
      r_armed <= r_armed | w_csb;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_nstate;
  end

  // FSM next state: CSB high always returns to IDLE.
  always_comb begin
    w_nstate = r_state;
    if (w_csb) begin
      w_nstate = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (r_armed)     w_nstate = S_CMD;
        S_CMD:   if (w_byte_done) w_nstate = S_ADDR;
        S_ADDR:  if (w_byte_done) w_nstate = S_DATA;
        S_DATA:                   w_nstate = S_DATA;
        default:                  w_nstate = S_IDLE;
      endcase
    end
  end

  // FSM outputs: qualified SCK edges and byte-boundary events.
  always_comb begin
    w_active    = (r_state != S_IDLE) && !w_csb;
    w_rise_act  = r_rise && w_active;
    w_fall_act  = r_fall && w_active;
    w_byte      = {r_rx[6:0], r_sdi_d};
    w_byte_done = w_rise_act && (r_bitcnt == 3'd7);
    w_cmd_done  = w_byte_done && (r_state == S_CMD);
    w_addr_done = w_byte_done && (r_state == S_ADDR);
    w_data_done = w_byte_done && (r_state == S_DATA);
  end

  // Receive shifter; a partial byte is dropped whenever the frame is inactive.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bitcnt <= 3'd0;
      r_rx     <= 8'h00;
    end else if (!w_active) begin
      r_bitcnt <= 3'd0;
      r_rx     <= 8'h00;
    end else if (w_rise_act) begin
      r_bitcnt <= r_bitcnt + 3'd1;
      r_rx     <= w_byte;
    end
  end

  // Command latch: only the write and read bits matter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cmd_wr <= 1'b0;
      r_cmd_rd <= 1'b0;
    end else if (!w_active) begin
      r_cmd_wr <= 1'b0;
      r_cmd_rd <= 1'b0;
    end else if (w_cmd_done) begin
      r_cmd_wr <= w_byte[7];
      r_cmd_rd <= w_byte[6];
    end
  end

  // Register-file strobes. With a write command the address steps after the
  // write strobe and the next prefetch follows it, so a read+write prefetch
  // of address N always lands before the write to N.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      r_re <= 1'b0;
      if (w_addr_done) begin
        r_addr <= w_byte;
        r_re   <= r_cmd_rd;
      end else if (w_data_done) begin
        if (r_cmd_wr) begin
          r_wdata <= w_byte;
          r_we    <= 1'b1;
        end else if (r_cmd_rd) begin
          r_addr <= r_addr + 8'd1;
          r_re   <= 1'b1;
        end
      end else if (r_we) begin
        r_addr <= r_addr + 8'd1;
        r_re   <= r_cmd_rd && w_active && (r_state == S_DATA);
      end
    end
  end

  // Transmit side: load prefetched data, shift MSB out on each SCK fall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_re_d    <= 1'b0;
      r_tx      <= 8'h00;
      r_sdo     <= 1'b0;
      r_sdo_enb <= 1'b1;
    end else begin
      r_re_d <= r_re;
      if (!w_active) begin
        r_tx      <= 8'h00;
        r_sdo     <= 1'b0;
        r_sdo_enb <= 1'b1;
      end else if (r_re_d && (r_state == S_DATA)) begin
        r_tx      <= reg_rdata;
        r_sdo_enb <= 1'b0;
      end else if (w_fall_act) begin
        r_sdo <= r_tx[7];
        r_tx  <= {r_tx[6:0], 1'b0};
      end
    end
  end

  assign SDO       = r_sdo;
  assign sdo_enb   = r_sdo_enb;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;

endmodule

// File: tb/tb_ravenna_hkspi.sv
// tb_ravenna_hkspi: SPI master + register file around ravenna_hkspi.
// Expected strobe sequences, SDO bytes and memory contents come from a
// frame-level model (address walk over a reference memory array).
module tb_ravenna_hkspi;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       resetn, SCK, CSB, SDI;
  logic       SDO, sdo_enb;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re;

  always #5 clk = ~clk;

  ravenna_hkspi #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .resetn(resetn), .SCK(SCK), .CSB(CSB), .SDI(SDI),
    .SDO(SDO), .sdo_enb(sdo_enb), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata)
  );

  // register file seen by the DUT, with a backdoor for preloading
  logic [7:0] mem [256];
  logic       bd_we = 1'b0;
  logic [7:0] bd_a = 8'h00, bd_d = 8'h00;
  always @(posedge clk) begin
    if (bd_we)       mem[bd_a] <= bd_d;
    else if (reg_we) mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  // strobe log: {is_write, addr, data}
  logic [16:0] ev_log [4096];
  int ev_cnt = 0;
  int bad_both = 0;
  always @(negedge clk) begin
    if (reg_we && reg_re) bad_both <= bad_both + 1;
    if (reg_we) begin
      ev_log[ev_cnt % 4096] <= {1'b1, reg_addr, reg_wdata};
      ev_cnt <= ev_cnt + 1;
    end else if (reg_re) begin
      ev_log[ev_cnt % 4096] <= {1'b0, reg_addr, 8'h00};
      ev_cnt <= ev_cnt + 1;
    end
  end

  int          n_chk = 0, n_fail = 0;
  logic [7:0]  ref_mem [256];
  logic [7:0]  tx_data [8];
  logic        sdo_bits [128];
  int          enb_err;
  logic [16:0] exp_q [$];
  logic [7:0]  exp_sdo [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    bd_a = a; bd_d = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // one SPI bit: data during low phase, SDO/sdo_enb sampled just before the rise
  task automatic spi_bit(input logic b, input int h, input int k, input logic exp_rd);
    logic exp_enb;
    SDI = b;
    repeat (h) @(negedge clk);
    exp_enb = !(exp_rd && k >= 16);
    if (sdo_enb !== exp_enb) enb_err++;
    sdo_bits[k] = SDO;
    SCK = 1'b1;
    repeat (h) @(negedge clk);
    SCK = 1'b0;
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] addr, input int nbits, input int h);
    logic [7:0] by;
    enb_err = 0;
    CSB = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      by = (k < 8) ? cmd : (k < 16) ? addr : tx_data[(k - 16) / 8];
      spi_bit(by[7 - (k % 8)], h, k, cmd[6]);
    end
    repeat (h + 8) @(negedge clk);
    CSB = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // frame model: prefetch at each address visited, write each complete byte
  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] addr, input int nbits);
    int nd;
    logic [7:0] a;
    exp_q.delete();
    nd = (nbits >= 16) ? (nbits - 16) / 8 : 0;
    a = addr;
    if (nbits < 16 || cmd[7:6] == 2'b00) return;
    for (int j = 0; j <= nd; j++) begin
      if (cmd[6]) begin
        exp_q.push_back({1'b0, a, 8'h00});
        if (j < nd) exp_sdo[j] = ref_mem[a];
      end
      if (j == nd) break;
      if (cmd[7]) begin
        exp_q.push_back({1'b1, a, tx_data[j]});
        ref_mem[a] = tx_data[j];
      end
      a = a + 8'd1;
    end
  endtask

  task automatic run_frame(input string nm, input logic [7:0] cmd, input logic [7:0] addr,
                           input int nbits, input int h);
    int base, got_n, nd;
    logic [7:0] sb;
    model_frame(cmd, addr, nbits);
    base = ev_cnt;
    spi_frame(cmd, addr, nbits, h);
    got_n = ev_cnt - base;
    chk({nm, ":nev"}, got_n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_n; i++)
      chk({nm, ":ev"}, {15'd0, ev_log[(base + i) % 4096]}, {15'd0, exp_q[i]});
    nd = (nbits >= 16) ? (nbits - 16) / 8 : 0;
    if (cmd[6]) begin
      for (int j = 0; j < nd; j++) begin
        for (int b = 0; b < 8; b++) sb[7 - b] = sdo_bits[16 + 8 * j + b];
        chk({nm, ":sdo"}, {24'd0, sb}, {24'd0, exp_sdo[j]});
      end
    end
    chk({nm, ":enb"}, enb_err, 0);
    chk({nm, ":enb_idle"}, {31'd0, sdo_enb}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [23:0] fr;
    int base, bad;
    logic [7:0] c, a;
    int nb, nbits, h;

    resetn = 1'b0; SCK = 1'b0; CSB = 1'b1; SDI = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst:SDO",   {31'd0, SDO},     32'd0);
    chk("rst:enb",   {31'd0, sdo_enb}, 32'd1);
    chk("rst:addr",  {24'd0, reg_addr},  32'd0);
    chk("rst:wdata", {24'd0, reg_wdata}, 32'd0);
    chk("rst:we",    {31'd0, reg_we},  32'd0);
    chk("rst:re",    {31'd0, reg_re},  32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 256; i++) begin
      bd_write(8'(i), ~8'(i));
      ref_mem[i] = ~8'(i);
    end

    tx_data[0] = 8'hA5;
    run_frame("wr1", 8'h80, 8'h12, 24, 5);

    tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h33;
    run_frame("rdwrap", 8'h40, 8'hFE, 40, 4);

    bd_write(8'h05, 8'h33); ref_mem[5] = 8'h33;
    tx_data[0] = 8'h7E;
    run_frame("rmw", 8'hC0, 8'h05, 24, 4);

    tx_data[0] = 8'hEE;
    run_frame("abort", 8'h80, 8'h20, 21, 5);
    tx_data[0] = 8'h5A;
    run_frame("after_abort", 8'h80, 8'h21, 24, 5);

    tx_data[0] = 8'hFF;
    run_frame("noop", 8'h00, 8'h10, 24, 5);

    // reset during the address byte, CSB held low across the release
    fr = 24'h8037A5;
    base = ev_cnt; enb_err = 0;
    CSB = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    for (int k = 0; k < 12; k++) spi_bit(fr[23 - k], 5, k, 1'b0);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int k = 12; k < 24; k++) spi_bit(fr[23 - k], 5, k, 1'b0);
    repeat (10) @(negedge clk);
    chk("rstmid:addr",  {24'd0, reg_addr},  32'd0);
    chk("rstmid:wdata", {24'd0, reg_wdata}, 32'd0);
    chk("rstmid:enb",   {31'd0, sdo_enb},   32'd1);
    chk("rstmid:SDO",   {31'd0, SDO},       32'd0);
    chk("rstmid:nev",   ev_cnt - base,      32'd0);
    chk("rstmid:enbs",  enb_err,            32'd0);
    CSB = 1'b1;
    repeat (8) @(negedge clk);
    tx_data[0] = 8'hC3;
    run_frame("post_rst", 8'h80, 8'h44, 24, 5);

    for (int r = 0; r < 25; r++) begin
      c  = 8'($urandom);
      a  = 8'($urandom);
      nb = $urandom_range(0, 4);
      nbits = 16 + 8 * nb;
      if ($urandom_range(0, 3) == 0) nbits = nbits + $urandom_range(1, 7);
      for (int j = 0; j < 8; j++) tx_data[j] = 8'($urandom);
      h = $urandom_range(4, 8);
      run_frame($sformatf("rnd%0d", r), c, a, nbits, h);
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("memcmp", bad, 0);
    chk("both_strobes", bad_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
